if_stage: RTL

- Instruction-fetch stage of the pipelined 16-bit CPU, directly upstream of the decode stage.
- Owns the PC register and the instruction-memory request/ready handshake.
- Owns the IF/ID pipeline register: instruction, PC+2 and a valid bit consumed by decode.
- Honours stall from the hazard unit, redirects PC on taken branches resolved in decode, and stops fetching after a HLT.

---
 rtl/if_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the instruction-memory request/ready
// handshake, a one-entry skid buffer for stalls, and the IF/ID pipeline register.
module if_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] if_id_instruction,
    output logic [15:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DROP = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] drop_addr_q, drop_addr_d;
    logic        buf_valid_q, buf_valid_d;
    logic [15:0] buf_instr_q, buf_instr_d;
    logic [15:0] buf_pc_q, buf_pc_d;
    logic [15:0] id_instr_q, id_instr_d;
    logic [15:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;

    logic        accept_s;
    logic        is_halt_s;
    logic [15:0] pc_plus2_s;

    // Memory request generation; a held request only ever changes after ready
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        if (rst) begin
            imem_req  = 1'b0;
            imem_addr = pc_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    imem_req  = !buf_valid_q;
                    imem_addr = pc_q;
                end
                ST_DROP: begin
                    imem_req  = 1'b1;
                    imem_addr = drop_addr_q;
                end
                ST_HALT: begin
                    imem_req  = 1'b0;
                    imem_addr = pc_q;
                end
                default: begin
                    imem_req  = 1'b0;
                    imem_addr = pc_q;
                end
            endcase
        end
    end

    // Handshake decode: an accepted word is one we keep (not killed by redirect)
    always_comb begin
        pc_plus2_s = pc_q + 16'd2;
        is_halt_s  = (imem_rdata[15:12] == HALT_OPCODE);
        accept_s   = (state_q == ST_RUN) && imem_req && imem_ready && !redirect;
    end

    // Next-state logic: redirect beats stall beats normal IF/ID advance
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
        id_valid_d  = id_valid_q;

        if (redirect) begin
            pc_d        = redirect_pc;
            id_instr_d  = NOP_INSTR;
            id_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
            case (state_q)
                ST_RUN: begin
                    // An unanswered request cannot be withdrawn: remember its
                    // address and swallow the response when it shows up.
                    if (imem_req && !imem_ready) begin
                        drop_addr_d = pc_q;
                        state_d     = ST_DROP;
                    end else begin
                        state_d     = ST_RUN;
                    end
                end
                ST_DROP: begin
                    if (imem_ready) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                ST_HALT: state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end else begin
            if (accept_s) begin
                pc_d = pc_plus2_s;
                if (is_halt_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end else if ((state_q == ST_DROP) && imem_ready) begin
                state_d = ST_RUN;
            end else begin
                state_d = state_q;
            end

            if (stall) begin
                // IF/ID frozen; a word arriving now parks in the skid buffer
                if (accept_s) begin
                    buf_valid_d = 1'b1;
                    buf_instr_d = imem_rdata;
                    buf_pc_d    = pc_plus2_s;
                end else begin
                    buf_valid_d = buf_valid_q;
                end
            end else if (buf_valid_q) begin
                id_instr_d  = buf_instr_q;
                id_pc_d     = buf_pc_q;
                id_valid_d  = 1'b1;
                buf_valid_d = 1'b0;
            end else if (accept_s) begin
                id_instr_d  = imem_rdata;
                id_pc_d     = pc_plus2_s;
                id_valid_d  = 1'b1;
            end else begin
                id_instr_d  = NOP_INSTR;
                id_valid_d  = 1'b0;
            end
        end
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= 16'h0000;
            id_instr_q  <= NOP_INSTR;
            id_pc_q     <= 16'h0000;
            id_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            id_valid_q  <= id_valid_d;
        end
    end

    // Pipeline outputs straight from flops
    always_comb begin
        if_id_instruction = id_instr_q;
        if_id_pc          = id_pc_q;
        if_id_valid       = id_valid_q;
        halted            = (state_q == ST_HALT);
    end

endmodule
